// File: rtl/sha256_round_rewind.sv
// Iterative SHA-256 round inverter: undoes one compression round per accepted kw beat.
// Optional final-state comparator enabled by defining SHA256_REWIND_MATCH_EN.
module sha256_round_rewind #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [255:0]     state_in,
  input  logic [CNT_W-1:0] num_rounds,
  input  logic [31:0]      kw,
  input  logic             kw_valid,
  output logic             kw_ready,
  output logic             busy,
  output logic [255:0]     state_out,
  output logic             done
`ifdef SHA256_REWIND_MATCH_EN
  ,
  input  logic [255:0]     match_state,
  output logic             match
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [255:0]     st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nr_clamped;
  logic             xfer;
  logic [255:0]     prev;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  assign nr_clamped = (num_rounds > CNT_W'(64)) ? CNT_W'(64) : num_rounds;
  assign xfer       = (fsm_q == StRun) && kw_valid;

  // Inverse round: the shifted words come straight back, only d and h need arithmetic.
  always_comb begin
    logic [31:0] na, nb, nc, nd, ne, nf, ng, nh;
    logic [31:0] pa, pb, pc, pd, pe, pf, pg, ph;
    logic [31:0] t1, t2;
    {na, nb, nc, nd, ne, nf, ng, nh} = st_q;
    pa = nb;
    pb = nc;
    pc = nd;
    pe = nf;
    pf = ng;
    pg = nh;
    t2 = bsig0(pa) + ((pa & pb) ^ (pa & pc) ^ (pb & pc));
    t1 = na - t2;
    pd = ne - t1;
    ph = t1 - bsig1(pe) - ((pe & pf) ^ (~pe & pg)) - kw;
    prev = {pa, pb, pc, pd, pe, pf, pg, ph};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= StIdle;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle: begin
        if (start) begin
          fsm_d = (nr_clamped == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (xfer && (cnt_q == CNT_W'(1))) begin
          fsm_d = StDone;
        end
      end
      StDone:  fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  always_comb begin
    kw_ready  = (fsm_q == StRun);
    busy      = (fsm_q == StRun) || (fsm_q == StDone);
    done      = (fsm_q == StDone);
    state_out = st_q;
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if ((fsm_q == StIdle) && start) begin
      st_d  = state_in;
      cnt_d = nr_clamped;
    end else if (xfer) begin
      st_d  = prev;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef SHA256_REWIND_MATCH_EN
  logic match_q;

  // Evaluated on the edge entering DONE so it lines up with the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_q <= 1'b0;
    end else if ((fsm_d == StDone) && (fsm_q != StDone)) begin
      match_q <= (st_d == match_state);
    end else begin
      match_q <= 1'b0;
    end
  end

  assign match = match_q;
`endif

endmodule

// File: tb/tb_sha256_round_rewind.sv
// Directed bench for sha256_round_rewind; forward SHA-256 rounds of "abc" generate the vectors.
// Define SHA256_REWIND_MATCH_EN to also exercise the match comparator.
module tb_sha256_round_rewind;
  localparam int unsigned CW = 7;
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic          clk = 1'b0;
  logic          rst_n, start, kw_valid, kw_ready, busy, done;
  logic [255:0]  state_in, state_out;
  logic [CW-1:0] num_rounds;
  logic [31:0]   kw;
  logic          match_w;
  logic [255:0]  match_state;

  int errors = 0;
  int checks = 0;

  logic [31:0]  w     [64];
  logic [31:0]  kwabc [64];
  logic [31:0]  kwq   [64];
  logic [255:0] fwd   [65];

  sha256_round_rewind #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .state_in   (state_in),
    .num_rounds (num_rounds),
    .kw         (kw),
    .kw_valid   (kw_valid),
    .kw_ready   (kw_ready),
    .busy       (busy),
    .state_out  (state_out),
    .done       (done)
`ifdef SHA256_REWIND_MATCH_EN
    ,
    .match_state(match_state),
    .match      (match_w)
`endif
  );

`ifndef SHA256_REWIND_MATCH_EN
  assign match_w = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] fwd_round(input logic [255:0] s, input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + k;
    t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one rewind using kwq[0..]; gaps drops kw_valid on loop cycles 1 and 2,
  // inject pulses a conflicting start while busy.
  task automatic run(input string tag, input logic [255:0] sin, input logic [CW-1:0] nr,
                     input bit gaps, input bit inject,
                     output logic [255:0] res, output int cyc, output logic mt);
    int  j;
    int  c;
    logic xf;
    state_in   = sin;
    num_rounds = nr;
    start      = 1'b1;
    kw_valid   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    j   = 0;
    c   = 0;
    while (!done && cyc < 300) begin
      kw_valid = gaps ? !(c == 1 || c == 2) : 1'b1;
      kw       = (j < 64) ? kwq[j] : 32'h0;
      if (inject && c == 3) begin
        start      = 1'b1;
        state_in   = ~sin;
        num_rounds = CW'(5);
      end
      xf = kw_valid && kw_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (xf) j++;
      c++;
      cyc++;
    end
    kw_valid = 1'b0;
    chk({tag, "_done_seen"}, {255'd0, done}, 256'd1);
    res = state_out;
    mt  = match_w;
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, {255'd0, done}, 256'd0);
  endtask

  logic [255:0] res, res_nogap, sin;
  int           cyc;
  logic         mt;
  bit           saw_done;

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    kw_valid    = 1'b0;
    kw          = '0;
    state_in    = '0;
    num_rounds  = '0;
    match_state = IV;

    for (int t = 0; t < 64; t++) w[t] = 32'h0;
    w[0]  = 32'h61626380;
    w[15] = 32'h00000018;
    for (int t = 16; t < 64; t++) begin
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
             (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    fwd[0] = IV;
    for (int t = 0; t < 64; t++) begin
      kwabc[t] = K[t] + w[t];
      fwd[t+1] = fwd_round(fwd[t], kwabc[t]);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state_out, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_ready", {255'd0, kw_ready}, 256'd0);
    chk("rst_done", {255'd0, done}, 256'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single round from the hand vector.
    kwq[0] = 32'ha3ec9318;
    run("one", {32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab},
        CW'(1), 1'b0, 1'b0, res, cyc, mt);
    chk("one_state", res, IV);
    chk("one_cyc", 256'(cyc), 256'd1);
    chk("idle_hold", state_out, IV);

    // Zero rounds passes state_in through.
    sin = {8{32'hdeadbeef}} ^ {32{8'h5a}};
    run("zero", sin, CW'(0), 1'b0, 1'b0, res, cyc, mt);
    chk("zero_state", res, sin);
    chk("zero_cyc", 256'(cyc), 256'd0);

    // Full 64-round rewind to the IV.
    for (int t = 0; t < 64; t++) kwq[t] = kwabc[63 - t];
    run("full", fwd[64], CW'(64), 1'b0, 1'b0, res, cyc, mt);
    chk("full_state", res, IV);
    chk("full_cyc", 256'(cyc), 256'd64);
`ifdef SHA256_REWIND_MATCH_EN
    chk("full_match", {255'd0, mt}, 256'd1);
    chk("match_low_after", {255'd0, match_w}, 256'd0);
`endif

    // Oversized count clamps to 64.
    run("clamp", fwd[64], CW'(127), 1'b0, 1'b0, res, cyc, mt);
    chk("clamp_state", res, IV);
    chk("clamp_cyc", 256'(cyc), 256'd64);

    // 8 rounds: no gaps, then with two idle cycles, then with a stray start.
    for (int t = 0; t < 8; t++) kwq[t] = kwabc[7 - t];
    run("nogap", fwd[8], CW'(8), 1'b0, 1'b0, res_nogap, cyc, mt);
    chk("nogap_state", res_nogap, IV);
    chk("nogap_cyc", 256'(cyc), 256'd8);
    run("gap", fwd[8], CW'(8), 1'b1, 1'b0, res, cyc, mt);
    chk("gap_state", res, res_nogap);
    chk("gap_cyc", 256'(cyc), 256'd10);
    run("inject", fwd[8], CW'(8), 1'b0, 1'b1, res, cyc, mt);
    chk("inject_state", res, IV);
    chk("inject_cyc", 256'(cyc), 256'd8);

    // E < T1 and T1 < kw force borrows in d and h.
    kwq[0] = 32'h00000020;
    sin = {32'h00000010, 32'h0, 32'h0, 32'h0, 32'h00000005, 32'h0, 32'h0, 32'h0};
    run("wrap", sin, CW'(1), 1'b0, 1'b0, res, cyc, mt);
    chk("wrap_state", res, {32'h0, 32'h0, 32'h0, 32'hfffffff5,
                            32'h0, 32'h0, 32'h0, 32'hfffffff0});
    chk("wrap_fwd", fwd_round(res, 32'h00000020), sin);

    // Reset after 3 of 10 beats.
    for (int t = 0; t < 10; t++) kwq[t] = kwabc[9 - t];
    state_in   = fwd[10];
    num_rounds = CW'(10);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      kw_valid = 1'b1;
      kw       = kwq[t];
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_state", state_out, 256'd0);
    chk("mrst_busy", {255'd0, busy}, 256'd0);
    chk("mrst_ready", {255'd0, kw_ready}, 256'd0);
    chk("mrst_done", {255'd0, done}, 256'd0);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int t = 0; t < 12; t++) begin
      kw = kwq[3];
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    kw_valid = 1'b0;
    chk("mrst_nodone", {255'd0, saw_done}, 256'd0);
    chk("mrst_hold", state_out, 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sha256_round_rewind.md
# sha256_round_rewind

Iterative SHA-256 compression-round inverter: given a 256-bit working state after round t and a stream of K+W sums for rounds t, t-1, …, it recovers the working state before those rounds, one round per accepted beat. It sits beside the forward round core in the miner datapath. It serves nonce-search debug and cross-checking: it walks a midstate back toward the IV to prove the forward pipeline is correct. It uses the same fixed-rotate Σ0/Σ1 functions as the forward core.

## Interface
- `CNT_W`, default 7; width of the round counter and of `num_rounds` (max 64 rounds).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  1-cycle request; sampled only in IDLE.
- `state_in`  in  256  {a,b,c,d,e,f,g,h}; a = [255:224], h = [31:0].
- `num_rounds`  in  CNT_W  rounds to undo, 0..64; sampled with `start`.
- `kw`  in  32  K_t + W_t (mod 2^32) for the round being undone; descending t.
- `kw_valid`  in  1  `kw` beat present.
- `kw_ready`  out  1  block accepts a beat this cycle.
- `busy`  out  1  high in RUN and DONE.
- `state_out`  out  256  rewound state, same packing as `state_in`.
- `done`  out  1  1-cycle completion pulse.
- `match_state`  in  256  expected final state (only with macro).
- `match`  out  1  final state == `match_state` (only with macro).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `start` when `num_rounds` ≠ 0. Capture `state_in` into the state register and load the counter with `num_rounds`.
- IDLE → DONE on `start` when `num_rounds` = 0. The state register loads `state_in` unchanged.
- RUN: `kw_ready` = 1. A beat transfers when `kw_valid` and `kw_ready` are both high. On each transfer, with new state (A..H) and previous state (a..h):
  - a=B, b=C, c=D, e=F, f=G, g=H
  - T2 = Σ0(a) + Maj(a,b,c); T1 = A − T2
  - d = E − T1
  - h = T1 − Σ1(e) − Ch(e,f,g) − kw
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - All arithmetic is 32-bit modulo 2^32; borrows are discarded.
- Each transfer decrements the counter. RUN → DONE on the transfer that takes the counter from 1 to 0.
- No transfer when `kw_valid` = 0: state and counter hold, and `kw_ready` stays high.
- DONE: `done` = 1 for exactly one cycle, then the FSM goes to IDLE.
- `state_out` always drives the state register. It holds its value in IDLE until the next accepted `start`.
- `start` while `busy` is ignored and has no side effects.
- `num_rounds` > 64 is clamped to 64.
- Reset (any cycle, including mid-RUN): FSM → IDLE. `state_out` = 0, counter = 0, `kw_ready` = 0, `busy` = 0, `done` = 0, `match` = 0. Any partial rewind is discarded.

## Timing
- `start` accepted at edge n: RUN from n+1, so the first `kw` transfer can occur at edge n+1.
- With `kw_valid` held high, N rounds complete at edge n+N. `done` is high during cycle n+N+1, and `state_out` is already final in that cycle.
- Throughput: 1 round per cycle. Rewind logic is a single combinational stage ahead of the state register, with no internal pipelining.
- `num_rounds` = 0: `done` is high during cycle n+1.
- `kw_ready` is registered from FSM state only; it does not depend on `kw_valid`.
- Earliest next `start` is the cycle after `done`.

## Configuration
- `SHA256_REWIND_MATCH_EN` defined:
  - `match_state` and `match` exist.
  - `match` is registered together with `done` and is valid only in the `done` cycle.
  - It equals 1 iff the final state equals `match_state`; it is 0 in all other cycles.
- Not defined: both ports are absent and no comparator is built.

## Test plan
- Single round, "abc" block:
  - Stimulus: `state_in` = 5D6AEBCD 6A09E667 BB67AE85 3C6EF372 FA2A4622 510E527F 9B05688C 1F83D9AB; `num_rounds` = 1; `kw` = A3EC9318.
  - Response: `state_out` = 6A09E667 BB67AE85 3C6EF372 A54FF53A 510E527F 9B05688C 1F83D9AB 5BE0CD19; `done` 2 cycles after `start`.
- Full 64-round rewind: take the post-round-63 state of the "abc" block and feed K63+W63 … K0+W0. Required: `state_out` = IV. With the macro and `match_state` = IV: `match` = 1 in the `done` cycle.
- Backpressure: toggle `kw_valid` 1-0-0-1 during an 8-round rewind. Required: the result equals the no-gap run, and `done` is delayed by exactly the 2 idle cycles.
- Zero rounds / ignored start: `num_rounds` = 0 gives `state_out` = `state_in` and `done` at n+1. A `start` mid-RUN with different `state_in` leaves the result unchanged.
- Reset mid-RUN: assert `rst_n` = 0 after 3 of 10 beats. Required: the next cycle shows `state_out` = 0, `busy` = 0, `kw_ready` = 0, and no `done` pulse.
- Wrap arithmetic: choose E < T1 so that d = E − T1 borrows. Required: d matches a 32-bit modulo reference model.
